// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer ring: destination types, entry states and the entry payload.
package rob_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM    = 2'd0,
    REG    = 2'd1,
    BRANCH = 2'd2,
    JL     = 2'd3
  } dest_type_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e    state;
    dest_type_e      dtype;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
    logic            mispred;
    logic [XLEN-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit ring pointer: TAG_W index bits plus one wrap bit, with increment and synchronous clear.
module rob_ptr #(
  parameter int unsigned TAG_W = 4
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           inc_in,
  input  logic           clr_in,
  output logic [TAG_W:0] ptr_out
);

  localparam int unsigned PW = TAG_W + 1;

  // Depth is a power of two, so natural overflow of the PW-bit value gives the wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_out <= '0;
    end else if (clr_in) begin
      ptr_out <= '0;
    end else if (inc_in) begin
      ptr_out <= ptr_out + PW'(1);
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Reorder buffer ring: in-order allocate/commit, multi-channel CDB writeback, operand lookup, mispredict flush.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB results to the operand lookups.
module rob_ring
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TAG_W   = $clog2(DEPTH),
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    alloc_valid_in,
  output logic                    alloc_ready_out,
  input  logic [1:0]              alloc_type_in,
  input  logic [4:0]              alloc_rd_in,
  output logic [TAG_W-1:0]        alloc_tag_out,
  input  logic [NUM_CDB-1:0]      cdb_valid_in,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_in,
  input  logic [NUM_CDB*32-1:0]   cdb_value_in,
  input  logic [NUM_CDB-1:0]      cdb_mispred_in,
  input  logic [NUM_CDB*32-1:0]   cdb_target_in,
  input  logic [2*TAG_W-1:0]      q_tag_in,
  output logic [1:0]              q_ready_out,
  output logic [63:0]             q_value_out,
  output logic                    commit_valid_out,
  input  logic                    commit_ready_in,
  output logic [1:0]              commit_type_out,
  output logic [4:0]              commit_rd_out,
  output logic [31:0]             commit_value_out,
  output logic                    flush_out,
  output logic [31:0]             flush_pc_out,
  output logic [TAG_W:0]          count_out
);

  localparam int unsigned PW = TAG_W + 1;

  rob_entry_t       rob_q [DEPTH];
  rob_entry_t       head_e;
  logic [PW-1:0]    head_ptr, tail_ptr;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, alloc_fire, commit_fire;

  logic [TAG_W-1:0] cdb_tag    [NUM_CDB];
  logic [XLEN-1:0]  cdb_value  [NUM_CDB];
  logic [XLEN-1:0]  cdb_target [NUM_CDB];
  logic [DEPTH-1:0] wb_en, wb_mispred;
  logic [XLEN-1:0]  wb_value   [DEPTH];
  logic [XLEN-1:0]  wb_target  [DEPTH];
  logic [TAG_W-1:0] q_idx      [2];

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .inc_in  (commit_fire),
    .clr_in  (flush_out),
    .ptr_out (head_ptr)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .inc_in  (alloc_fire),
    .clr_in  (flush_out),
    .ptr_out (tail_ptr)
  );

  assign head_idx        = head_ptr[TAG_W-1:0];
  assign tail_idx        = tail_ptr[TAG_W-1:0];
  assign count_out       = tail_ptr - head_ptr;
  assign full            = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
  assign alloc_ready_out = ~full;
  assign alloc_tag_out   = tail_idx;
  assign alloc_fire      = alloc_valid_in & ~full & rdy_in;

  assign head_e           = rob_q[head_idx];
  assign commit_valid_out = (head_e.state == DONE);
  assign commit_fire      = commit_valid_out & commit_ready_in & rdy_in;
  assign commit_type_out  = head_e.dtype;
  assign commit_rd_out    = head_e.rd;
  assign commit_value_out = head_e.value;
  assign flush_out        = commit_fire & head_e.mispred;
  assign flush_pc_out     = flush_out ? head_e.target : '0;

  always_comb begin
    for (int c = 0; c < int'(NUM_CDB); c++) begin
      cdb_tag[c]    = cdb_tag_in[c*TAG_W +: TAG_W];
      cdb_value[c]  = cdb_value_in[c*XLEN +: XLEN];
      cdb_target[c] = cdb_target_in[c*XLEN +: XLEN];
    end
  end

  // Per-entry writeback select; scanning channels high-to-low lets the lowest index win.
  always_comb begin
    wb_en      = '0;
    wb_mispred = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wb_value[i]  = '0;
      wb_target[i] = '0;
      for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
        if (rdy_in && cdb_valid_in[c] && (cdb_tag[c] == TAG_W'(i)) && (rob_q[i].state == BUSY)) begin
          wb_en[i]      = 1'b1;
          wb_value[i]   = cdb_value[c];
          wb_mispred[i] = cdb_mispred_in[c];
          wb_target[i]  = cdb_target[c];
        end
      end
    end
  end

  always_comb begin
    q_ready_out = '0;
    q_value_out = '0;
    for (int k = 0; k < 2; k++) begin
      q_idx[k] = q_tag_in[k*TAG_W +: TAG_W];
      if (rob_q[q_idx[k]].state == DONE) begin
        q_ready_out[k]              = 1'b1;
        q_value_out[k*XLEN +: XLEN] = rob_q[q_idx[k]].value;
      end
`ifdef ROB_CDB_BYPASS_EN
      if (wb_en[q_idx[k]]) begin
        q_ready_out[k]              = 1'b1;
        q_value_out[k*XLEN +: XLEN] = wb_value[q_idx[k]];
      end
`endif
    end
  end

  // Entry storage; a flush discards any same-cycle allocation and writeback.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rob_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_out) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          rob_q[i].state <= EMPTY;
        end
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (wb_en[i]) begin
            rob_q[i].state   <= DONE;
            rob_q[i].value   <= wb_value[i];
            rob_q[i].mispred <= wb_mispred[i];
            rob_q[i].target  <= wb_target[i];
          end
        end
        if (commit_fire) begin
          rob_q[head_idx].state <= EMPTY;
        end
        if (alloc_fire) begin
          rob_q[tail_idx].state   <= BUSY;
          rob_q[tail_idx].dtype   <= dest_type_e'(alloc_type_in);
          rob_q[tail_idx].rd      <= alloc_rd_in;
          rob_q[tail_idx].mispred <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rob_ring.md
ROB_RING -- requirements
Module: rob_ring

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, at least 4.
REQ-002 Parameter TAG_W, default $clog2(DEPTH), tag width; tag equals entry index.
REQ-003 Parameter NUM_CDB, default 2, number of CDB writeback channels.
REQ-004 clk_in  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 alloc_valid_in  input  1  allocation request.
REQ-008 alloc_ready_out  output  1  high when not full.
REQ-009 alloc_type_in  input  2  destination type (MEM/REG/BRANCH/JL).
REQ-010 alloc_rd_in  input  5  destination register.
REQ-011 alloc_tag_out  output  TAG_W  tag the next allocation receives (tail index).
REQ-012 cdb_valid_in  input  NUM_CDB  per-channel writeback valid.
REQ-013 cdb_tag_in  input  NUM_CDB*TAG_W  per-channel tag.
REQ-014 cdb_value_in  input  NUM_CDB*32  per-channel result.
REQ-015 cdb_mispred_in  input  NUM_CDB  branch/JL mispredicted.
REQ-016 cdb_target_in  input  NUM_CDB*32  correct next PC when mispredicted.
REQ-017 q_tag_in  input  2*TAG_W  two operand-lookup tags.
REQ-018 q_ready_out  output  2  lookup entry holds a result.
REQ-019 q_value_out  output  64  lookup results.
REQ-020 commit_valid_out  output  1  head entry is committable.
REQ-021 commit_ready_in  input  1  consumer accepts commit.
REQ-022 commit_type_out / commit_rd_out / commit_value_out  output  2/5/32  head entry fields.
REQ-023 flush_out  output  1  mispredicted entry is committing.
REQ-024 flush_pc_out  output  32  redirect PC, valid with flush_out.
REQ-025 count_out  output  TAG_W+1  occupied entries.

Function
REQ-026 Entry states EMPTY, BUSY, DONE; head/tail pointers TAG_W+1 bits with a wrap bit; full when indices are equal and wrap bits differ; empty when pointers are equal.
REQ-027 Allocation fires on alloc_valid_in & alloc_ready_out & rdy_in: tail entry becomes BUSY, type and rd are stored, mispred is cleared, tail advances with wrap.
REQ-028 alloc_ready_out derives from registered count only; a full ROB refuses allocation even in a cycle where it commits.
REQ-029 CDB: each valid channel whose tag addresses a BUSY entry sets it DONE and stores value, mispred and target; a tag addressing an EMPTY or DONE entry is ignored; when two channels carry the same tag, the lowest channel index wins.
REQ-030 commit_valid_out = (head state == DONE) from registered state; commit fires on commit_valid_out & commit_ready_in & rdy_in; the head entry then becomes EMPTY and head advances.
REQ-031 A CDB write to the head entry becomes committable the following cycle; minimum latency: allocate in cycle N, CDB in N+1, commit_valid_out in N+2.
REQ-032 Allocation and commit in the same cycle leave count unchanged.
REQ-033 flush_out = commit fire & head mispred, combinationally; flush_pc_out = head target, and is 0 otherwise.
REQ-034 On the edge ending a flush cycle, every entry becomes EMPTY, head = tail = 0, and any simultaneous allocation and CDB writes are discarded.
REQ-035 Lookup: q_ready_out[k] = entry(q_tag_in[k]) DONE; q_value_out[k] = the stored value, or 0 when not ready.
REQ-036 With rdy_in low: no allocation, commit, CDB capture or flush takes effect; outputs reflect the frozen state.

Reset
REQ-037 While rst_n_in is low, asynchronously: all entries EMPTY, head = tail = 0, count_out 0, alloc_ready_out 1, alloc_tag_out 0, commit_valid_out 0, flush_out 0, q_ready_out 0; reset mid-operation discards all contents.

Configuration
REQ-038 With ROB_CDB_BYPASS_EN defined, a lookup whose tag matches a valid CDB channel this cycle targeting a BUSY entry SHALL return ready = 1 and that channel's value (lowest channel index wins); when undefined, lookups see registered state only.

Structure
REQ-039 Package rob_pkg holds: the destination-type enum (MEM=0, REG=1, BRANCH=2, JL=3), the entry-state enum, and XLEN=32.
REQ-040 Sub-module rob_ptr implements the wrap-bit pointer with increment and clear; it is instantiated twice (head, tail).

Verification
REQ-041 Allocate DEPTH entries -> alloc_ready_out = 0 and count_out = 16; the 17th request is not accepted.
REQ-042 Allocate tags 0 and 1; CDB writes tag 1 value 0x55, then tag 0 value 0xAA -> commits occur in order: 0xAA, then 0x55.
REQ-043 Both CDB channels write tag 3 in the same cycle (values 0x1 and 0x2) -> the stored value is 0x1.
REQ-044 BRANCH entry at head with mispred = 1 and target 0x1000 commits -> flush_out = 1 and flush_pc_out = 0x1000 in that cycle, count_out = 0 on the next cycle, and an allocation in the flush cycle is dropped.
REQ-045 Lookup tag 2 in the same cycle as a CDB write of 0x77 to tag 2 -> ready = 1 and value 0x77 with ROB_CDB_BYPASS_EN; ready = 0 without it.
REQ-046 Fill, drain and refill across the wrap point with rdy_in toggling and rst_n_in asserted mid-stream -> pointers wrap correctly and all REQ-037 values appear immediately.
